ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Arbitrates the single-port synchronous data RAM between the CPU load/store port and an auxiliary master (debug/DMA scanner), and decodes the memory-mapped I/O words (button input, hex display register) so neither master touches RAM for them. Sits between the CPU data pins and the block RAM in the tester top level. The CPU has priority; an optional starvation guard bounds auxiliary wait time.

## Interface
- `ADDR_W`, 12, address width
- `DATA_W`, 16, data width
- `STARVE_MAX`, 4, consecutive CPU grants tolerated while aux pending (guard build only)
- `IO_BTN_ADDR`, 0, read-only button word address
- `IO_HEX_ADDR`, 1, write-only display register address

- `clk` in 1 system clock, rising edge
- `res` in 1 asynchronous, active-low reset
- `cpu_sel` in 1 CPU access request (level)
- `cpu_ld` in 1 1 = read, 0 = write
- `cpu_addr` in ADDR_W; `cpu_wdata` in DATA_W
- `cpu_rdata` out DATA_W registered read data; `cpu_ready` out 1 one-cycle completion pulse
- `aux_req`, `aux_ld`, `aux_addr`, `aux_wdata` in: same meaning for aux master
- `aux_rdata` out DATA_W; `aux_ready` out 1
- `mem_sel` out 1, `mem_ld` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: registered RAM controls
- `mem_rdata` in DATA_W: RAM output, valid one cycle after `mem_sel`
- `btn` in 2 raw active-low buttons
- `hex4` out DATA_W display value register

## Operation
- States: IDLE, ACC, RESP.
- IDLE/RESP arbitration: CPU wins if `cpu_sel`; else aux if `aux_req`; else IDLE. Winner's `ld/addr/wdata` latched; next state ACC.
- ACC: `mem_sel`=1 for exactly one cycle with latched controls, unless address is I/O (then `mem_sel`=0). Next RESP.
- RESP: read data selected: RAM → `mem_rdata`; `IO_BTN_ADDR` read → `{14'b0, ~btn}`. Registered into the winner's `*_rdata`; winner's `*_ready` pulses the following cycle. Write to `IO_HEX_ADDR` loads `hex4` with wdata; write to `IO_BTN_ADDR` is dropped; read of `IO_HEX_ADDR` returns `hex4`.
- Requests are levels: a request still asserted at the next arbitration point is a new access. Masters hold addr/data stable until `*_ready`.
- Only the granted master's `*_rdata` changes; the other retains its value.
- Reset: state IDLE, all `mem_*`, `*_ready`, `*_rdata`, `hex4`, starvation counter = 0. Reset mid-access abandons it; no ready issued.

## Timing
- Request sampled at edge E0 (IDLE) → `mem_sel` high E0..E1 → RESP E1..E2 → `*_ready` high E2..E3. Request-to-ready latency 3 cycles from IDLE.
- Back-to-back: arbitration in RESP, so one access per 2 cycles sustained.
- `*_ready` and `*_rdata` update on the same edge; data valid while ready is high and held afterwards.
- Simultaneous CPU and aux requests: CPU granted (subject to guard).

## Configuration
- `ARB_STARVE_GUARD_EN` defined: 3-bit counter increments each CPU grant made while `aux_req`=1; when counter = `STARVE_MAX`, aux wins the next arbitration regardless of `cpu_sel`; counter clears on any aux grant or when `aux_req`=0 at arbitration.
- Not defined: strict CPU priority; aux may starve indefinitely; no counter logic.

## Structure
- Shared package: state encoding (IDLE/ACC/RESP), master-id constant (CPU=0, AUX=1), I/O address defaults.
- One sub-module `io_decode`: combinational address match plus `hex4` register, keeping I/O map separate from arbitration FSM.

## Test plan
- CPU write 0x1234 to addr 5, then read addr 5 → `mem_sel` one cycle each, `cpu_ready` 3 cycles after request, `cpu_rdata`=0x1234.
- CPU write 0xBEEF to addr 1 → `hex4`=0xBEEF, `mem_sel` stays 0; read addr 0 with `btn`=2'b10 → `cpu_rdata`=0x0001.
- CPU and aux request same cycle → CPU ready first, aux ready 2 cycles later; `aux_rdata` unchanged during CPU access.
- Guard build, `cpu_sel` and `aux_req` held high → exactly 4 CPU grants then 1 aux grant, repeating; non-guard build → zero aux grants over 50 cycles.
- `res` low during ACC → all outputs 0 asynchronously, no ready pulse; after release, fresh read completes normally.
- Aux read addr 7 with CPU idle → `aux_ready` at cycle 3, `cpu_ready` never pulses.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared FSM states, master ids, I/O map defaults.
// Optional starvation guard macro: ARB_STARVE_GUARD_EN.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_RESP
  } state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int IO_BTN_DEF = 0;
  localparam int IO_HEX_DEF = 1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: CPU, aux, RAM and I/O pins of the arbiter.
// slave = arbiter side, master = CPU/aux/RAM/board side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);

  logic              cpu_sel;
  logic              cpu_ld;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              aux_req;
  logic              aux_ld;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_ready;

  logic              mem_sel;
  logic              mem_ld;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        btn;
  logic [DATA_W-1:0] hex4;

  modport slave (
    input  cpu_sel, cpu_ld, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  aux_req, aux_ld, aux_addr, aux_wdata,
    output aux_rdata, aux_ready,
    output mem_sel, mem_ld, mem_addr, mem_wdata,
    input  mem_rdata,
    input  btn,
    output hex4
  );

  modport master (
    output cpu_sel, cpu_ld, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output aux_req, aux_ld, aux_addr, aux_wdata,
    input  aux_rdata, aux_ready,
    input  mem_sel, mem_ld, mem_addr, mem_wdata,
    output mem_rdata,
    output btn,
    input  hex4
  );

endinterface

// File: rtl/ram_port_arbiter_io_decode.sv
// io_decode: I/O address match, read-data select, hex4 display register.
// Ports: grant_addr_i/grant_io_o, addr_i, wdata_i, we_i, btn_i, mem_rdata_i, rdata_o, hex4_o.
module io_decode
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int IO_BTN_ADDR = IO_BTN_DEF,
  parameter int IO_HEX_ADDR = IO_HEX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] grant_addr_i,
  output logic              grant_io_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic [1:0]        btn_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] hex4_o
);

  logic              is_btn;
  logic              is_hex;
  logic [DATA_W-1:0] hex_q;

  // new grant address decides whether the RAM is selected at all
  assign grant_io_o = (grant_addr_i == ADDR_W'(IO_BTN_ADDR))
                   || (grant_addr_i == ADDR_W'(IO_HEX_ADDR));

  assign is_btn = (addr_i == ADDR_W'(IO_BTN_ADDR));
  assign is_hex = (addr_i == ADDR_W'(IO_HEX_ADDR));

  always_comb begin
    rdata_o = mem_rdata_i;
    unique case (1'b1)
      is_btn:  rdata_o = {{(DATA_W-2){1'b0}}, ~btn_i};
      is_hex:  rdata_o = hex_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= '0;
    end else if (we_i && is_hex) begin
      hex_q <= wdata_i;
    end
  end

  assign hex4_o = hex_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: CPU-priority arbiter for one sync RAM port plus I/O words.
// Ports: clk, res (async active-low), bus (slave); guard macro ARB_STARVE_GUARD_EN.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int IO_BTN_ADDR = IO_BTN_DEF,
  parameter int IO_HEX_ADDR = IO_HEX_DEF
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input logic               clk,
  input logic               res,
  ram_port_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              ld_q, ld_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              aux_rdy_q, aux_rdy_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] aux_rd_q, aux_rd_d;

  logic              arb;
  logic              aux_force;
  logic              grant_cpu;
  logic              grant_aux;
  logic              grant_io;
  logic              hex_we;
  logic [DATA_W-1:0] rd_data;
  logic              win_ld;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // arbitration happens in IDLE and in RESP (back-to-back)
  assign arb = (state_q != S_ACC);

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign aux_force = bus.aux_req
                  && (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (arb) begin
      if (grant_aux || !bus.aux_req) begin
        cnt_d = '0;
      end else if (grant_cpu) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign aux_force = 1'b0;
`endif

  assign grant_cpu = bus.cpu_sel && !aux_force;
  assign grant_aux = bus.aux_req && !grant_cpu;

  always_comb begin
    win_ld    = bus.aux_ld;
    win_addr  = bus.aux_addr;
    win_wdata = bus.aux_wdata;
    unique case (1'b1)
      grant_cpu: begin
        win_ld    = bus.cpu_ld;
        win_addr  = bus.cpu_addr;
        win_wdata = bus.cpu_wdata;
      end
      default: ;
    endcase
  end

  io_decode #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .IO_BTN_ADDR (IO_BTN_ADDR),
    .IO_HEX_ADDR (IO_HEX_ADDR)
  ) u_io (
    .clk          (clk),
    .rst_n        (res),
    .grant_addr_i (win_addr),
    .grant_io_o   (grant_io),
    .addr_i       (addr_q),
    .wdata_i      (wdata_q),
    .we_i         (hex_we),
    .btn_i        (bus.btn),
    .mem_rdata_i  (bus.mem_rdata),
    .rdata_o      (rd_data),
    .hex4_o       (bus.hex4)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ld_d      = ld_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = 1'b0;
    cpu_rdy_d = 1'b0;
    aux_rdy_d = 1'b0;
    cpu_rd_d  = cpu_rd_q;
    aux_rd_d  = aux_rd_q;
    hex_we    = 1'b0;

    unique case (state_q)
      S_ACC: state_d = S_RESP;
      S_RESP: begin
        hex_we = !ld_q;
        if (id_q == M_AUX) begin
          aux_rdy_d = 1'b1;
          if (ld_q) aux_rd_d = rd_data;
        end else begin
          cpu_rdy_d = 1'b1;
          if (ld_q) cpu_rd_d = rd_data;
        end
      end
      default: ;
    endcase

    // latched controls of the finishing access are used above
    // before being overwritten by the new winner here
    if (arb) begin
      if (grant_cpu || grant_aux) begin
        state_d = S_ACC;
        id_d    = grant_aux ? M_AUX : M_CPU;
        ld_d    = win_ld;
        addr_d  = win_addr;
        wdata_d = win_wdata;
        sel_d   = !grant_io;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_IDLE;
      id_q      <= M_CPU;
      ld_q      <= 1'b0;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdy_q <= 1'b0;
      aux_rdy_q <= 1'b0;
      cpu_rd_q  <= '0;
      aux_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      ld_q      <= ld_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rdy_q <= cpu_rdy_d;
      aux_rdy_q <= aux_rdy_d;
      cpu_rd_q  <= cpu_rd_d;
      aux_rd_q  <= aux_rd_d;
    end
  end

  assign bus.mem_sel   = sel_q;
  assign bus.mem_ld    = ld_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ready = cpu_rdy_q;
  assign bus.aux_ready = aux_rdy_q;
  assign bus.cpu_rdata = cpu_rd_q;
  assign bus.aux_rdata = aux_rd_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a sync RAM model.
// Define ARB_STARVE_GUARD_EN to exercise the starvation guard build.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  ram_port_arbiter dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  logic [15:0] ram [0:4095];

  always @(posedge clk) begin
    if (bus.mem_sel) begin
      if (bus.mem_ld) bus.mem_rdata <= ram[bus.mem_addr];
      else            ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one-edge request; returns at the negedge after the grant edge
  task automatic pulse(input logic aux, input logic ld,
                       input logic [11:0] a, input logic [15:0] wd);
    @(negedge clk);
    if (aux) begin
      bus.aux_req = 1'b1; bus.aux_ld = ld;
      bus.aux_addr = a;   bus.aux_wdata = wd;
    end else begin
      bus.cpu_sel = 1'b1; bus.cpu_ld = ld;
      bus.cpu_addr = a;   bus.cpu_wdata = wd;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cpu_sel = 1'b0;
    bus.aux_req = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    bus.cpu_sel = 0; bus.cpu_ld = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.aux_req = 0; bus.aux_ld = 0; bus.aux_addr = 0; bus.aux_wdata = 0;
    bus.btn = 2'b11;
    repeat (3) step();
    checks++;
    if ({bus.mem_sel, bus.mem_ld, bus.mem_addr, bus.mem_wdata} !== 30'd0) begin
      errors++;
      $display("FAIL reset_mem got %h exp 0",
               {bus.mem_sel, bus.mem_ld, bus.mem_addr, bus.mem_wdata});
    end
    checks++;
    if ({bus.cpu_ready, bus.aux_ready, bus.cpu_rdata, bus.aux_rdata, bus.hex4}
        !== 50'd0) begin
      errors++;
      $display("FAIL reset_out got rdy %b%b rd %h %h hex %h",
               bus.cpu_ready, bus.aux_ready, bus.cpu_rdata,
               bus.aux_rdata, bus.hex4);
    end
    res = 1'b1;
    step();
  endtask

  task automatic test_cpu_ram();
    pulse(1'b0, 1'b0, 12'd5, 16'h1234);
    checks++;
    if ({bus.mem_sel, bus.mem_ld, bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 1'b0, 12'd5, 16'h1234}) begin
      errors++;
      $display("FAIL wr_mem got sel %b ld %b a %h d %h exp 1 0 005 1234",
               bus.mem_sel, bus.mem_ld, bus.mem_addr, bus.mem_wdata);
    end
    step();
    checks++;
    if ({bus.mem_sel, bus.cpu_ready} !== 2'b00) begin
      errors++;
      $display("FAIL wr_resp got sel %b rdy %b exp 0 0",
               bus.mem_sel, bus.cpu_ready);
    end
    step();
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready got %b exp 1", bus.cpu_ready);
    end
    step();
    checks++;
    if ({bus.cpu_ready, bus.mem_sel} !== 2'b00) begin
      errors++;
      $display("FAIL wr_after got rdy %b sel %b exp 0 0",
               bus.cpu_ready, bus.mem_sel);
    end
    pulse(1'b0, 1'b1, 12'd5, 16'h0000);
    checks++;
    if ({bus.mem_sel, bus.mem_ld} !== 2'b11) begin
      errors++;
      $display("FAIL rd_mem got sel %b ld %b exp 1 1",
               bus.mem_sel, bus.mem_ld);
    end
    step();
    step();
    checks++;
    if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL rd_data got rdy %b d %h exp 1 1234",
               bus.cpu_ready, bus.cpu_rdata);
    end
    step();
  endtask

  task automatic test_io();
    pulse(1'b0, 1'b0, 12'd1, 16'hBEEF);
    checks++;
    if (bus.mem_sel !== 1'b0) begin
      errors++;
      $display("FAIL hex_sel got %b exp 0", bus.mem_sel);
    end
    step();
    step();
    checks++;
    if ({bus.cpu_ready, bus.hex4} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL hex_wr got rdy %b hex %h exp 1 beef",
               bus.cpu_ready, bus.hex4);
    end
    bus.btn = 2'b10;
    pulse(1'b0, 1'b1, 12'd0, 16'h0000);
    checks++;
    if (bus.mem_sel !== 1'b0) begin
      errors++;
      $display("FAIL btn_sel got %b exp 0", bus.mem_sel);
    end
    step();
    step();
    checks++;
    if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL btn_rd got rdy %b d %h exp 1 0001",
               bus.cpu_ready, bus.cpu_rdata);
    end
    pulse(1'b0, 1'b0, 12'd0, 16'h5555);
    step();
    step();
    checks++;
    if ({bus.hex4, bus.cpu_rdata} !== {16'hBEEF, 16'h0001}) begin
      errors++;
      $display("FAIL btn_wr got hex %h rd %h exp beef 0001",
               bus.hex4, bus.cpu_rdata);
    end
    pulse(1'b0, 1'b1, 12'd1, 16'h0000);
    step();
    step();
    checks++;
    if (bus.cpu_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL hex_rd got %h exp beef", bus.cpu_rdata);
    end
    step();
  endtask

  task automatic test_aux();
    int cpu_pulses;
    cpu_pulses = 0;
    pulse(1'b1, 1'b0, 12'd7, 16'h7777);
    step();
    step();
    checks++;
    if (bus.aux_ready !== 1'b1) begin
      errors++;
      $display("FAIL aux_wr_rdy got %b exp 1", bus.aux_ready);
    end
    pulse(1'b1, 1'b1, 12'd7, 16'h0000);
    checks++;
    if ({bus.mem_sel, bus.mem_ld, bus.mem_addr}
        !== {1'b1, 1'b1, 12'd7}) begin
      errors++;
      $display("FAIL aux_rd_mem got sel %b ld %b a %h exp 1 1 007",
               bus.mem_sel, bus.mem_ld, bus.mem_addr);
    end
    if (bus.cpu_ready) cpu_pulses++;
    step();
    if (bus.cpu_ready) cpu_pulses++;
    step();
    if (bus.cpu_ready) cpu_pulses++;
    checks++;
    if ({bus.aux_ready, bus.aux_rdata} !== {1'b1, 16'h7777}) begin
      errors++;
      $display("FAIL aux_rd got rdy %b d %h exp 1 7777",
               bus.aux_ready, bus.aux_rdata);
    end
    step();
    if (bus.cpu_ready) cpu_pulses++;
    checks++;
    if (cpu_pulses !== 0) begin
      errors++;
      $display("FAIL aux_cpu_quiet got %0d cpu pulses exp 0", cpu_pulses);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.cpu_sel = 1; bus.cpu_ld = 1; bus.cpu_addr = 12'd5;
    bus.aux_req = 1; bus.aux_ld = 1; bus.aux_addr = 12'd1;
    step();
    bus.cpu_sel = 0;
    checks++;
    if ({bus.mem_sel, bus.mem_addr} !== {1'b1, 12'd5}) begin
      errors++;
      $display("FAIL both_grant got sel %b a %h exp 1 005",
               bus.mem_sel, bus.mem_addr);
    end
    step();
    step();
    bus.aux_req = 0;
    checks++;
    if ({bus.cpu_ready, bus.aux_ready, bus.cpu_rdata, bus.aux_rdata}
        !== {1'b1, 1'b0, 16'h1234, 16'h7777}) begin
      errors++;
      $display("FAIL both_cpu got rdy %b%b d %h %h exp 10 1234 7777",
               bus.cpu_ready, bus.aux_ready, bus.cpu_rdata, bus.aux_rdata);
    end
    checks++;
    if ({bus.mem_sel, bus.mem_addr} !== {1'b0, 12'd1}) begin
      errors++;
      $display("FAIL both_aux_grant got sel %b a %h exp 0 001",
               bus.mem_sel, bus.mem_addr);
    end
    step();
    step();
    checks++;
    if ({bus.cpu_ready, bus.aux_ready, bus.cpu_rdata, bus.aux_rdata}
        !== {1'b0, 1'b1, 16'h1234, 16'hBEEF}) begin
      errors++;
      $display("FAIL both_aux got rdy %b%b d %h %h exp 01 1234 beef",
               bus.cpu_ready, bus.aux_ready, bus.cpu_rdata, bus.aux_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int rdy;
    rdy = 0;
    pulse(1'b0, 1'b1, 12'd5, 16'h0000);
    #2 res = 1'b0;
    #1;
    checks++;
    if ({bus.mem_sel, bus.mem_addr, bus.cpu_ready, bus.cpu_rdata,
         bus.aux_rdata, bus.hex4} !== 62'd0) begin
      errors++;
      $display("FAIL rst_async got sel %b a %h rdy %b d %h %h hex %h",
               bus.mem_sel, bus.mem_addr, bus.cpu_ready, bus.cpu_rdata,
               bus.aux_rdata, bus.hex4);
    end
    repeat (3) begin
      step();
      if (bus.cpu_ready || bus.aux_ready) rdy++;
    end
    res = 1'b1;
    step();
    if (bus.cpu_ready || bus.aux_ready) rdy++;
    checks++;
    if (rdy !== 0) begin
      errors++;
      $display("FAIL rst_no_ready got %0d pulses exp 0", rdy);
    end
    pulse(1'b0, 1'b1, 12'd5, 16'h0000);
    step();
    step();
    checks++;
    if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL rst_fresh got rdy %b d %h exp 1 1234",
               bus.cpu_ready, bus.cpu_rdata);
    end
    step();
  endtask

  task automatic test_starve();
    int n_cpu;
    int n_aux;
    logic [9:0] seq;
    n_cpu = 0;
    n_aux = 0;
    seq = '0;
    @(negedge clk);
    res = 1'b0;
    step();
    res = 1'b1;
    bus.cpu_sel = 1; bus.cpu_ld = 1; bus.cpu_addr = 12'd5;
    bus.aux_req = 1; bus.aux_ld = 1; bus.aux_addr = 12'd5;
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < 60 && (n_cpu + n_aux) < 10; i++) begin
      step();
      if (bus.cpu_ready) begin
        n_cpu++;
        seq = {seq[8:0], 1'b0};
      end
      if (bus.aux_ready) begin
        n_aux++;
        seq = {seq[8:0], 1'b1};
      end
    end
    checks++;
    if ((n_cpu + n_aux) !== 10) begin
      errors++;
      $display("FAIL guard_budget got %0d grants exp 10", n_cpu + n_aux);
    end
    checks++;
    if (seq !== 10'b0000100001) begin
      errors++;
      $display("FAIL guard_order got %b exp 0000100001", seq);
    end
`else
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.cpu_ready) n_cpu++;
      if (bus.aux_ready) n_aux++;
    end
    checks++;
    if (n_aux !== 0) begin
      errors++;
      $display("FAIL strict_aux got %0d exp 0", n_aux);
    end
    checks++;
    if (n_cpu !== 24) begin
      errors++;
      $display("FAIL strict_cpu got %0d exp 24", n_cpu);
    end
`endif
    bus.cpu_sel = 0;
    bus.aux_req = 0;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_cpu_ram();
    test_io();
    test_aux();
    test_back_to_back();
    test_reset_mid();
    test_starve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
